// File: rtl/sha3_axis_pkg.sv
// Shared SHA3 block-packer definitions: mode encoding, rate lookup and padding bytes.
package sha3_axis_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_t;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;
  localparam int         RATE_MAX   = 1152;

  function automatic logic [7:0] rate_bytes(input sha3_mode_t m);
    case (m)
      SHA3_224: return 8'd144;
      SHA3_256: return 8'd136;
      SHA3_384: return 8'd104;
      default:  return 8'd72;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_inserter.sv
// Combinational SHA3 padding: masks the final beat, places it in the block and
// inserts the domain byte; also produces the end-of-rate 0x80 byte mask.
module sha3_pad_inserter #(
  parameter int DATA_WIDTH = 64,
  parameter int RATE_MAX   = 1152
) (
  input  logic [DATA_WIDTH-1:0]                   beat,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]       nbytes,
  input  logic [$clog2(RATE_MAX/DATA_WIDTH)-1:0]  word_pos,
  input  sha3_axis_pkg::sha3_mode_t               mode,
  output logic [RATE_MAX-1:0]                     padded,
  output logic [RATE_MAX-1:0]                     end_mask
);
  import sha3_axis_pkg::*;

  localparam int BPW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] beat_pad;
  logic [7:0]            rate;

  assign rate = rate_bytes(mode);

  always_comb begin
    beat_pad = '0;
    for (int b = 0; b < BPW; b++) begin
      if (b < int'(nbytes))
        beat_pad[b*8 +: 8] = beat[b*8 +: 8];
      else if (b == int'(nbytes))
        beat_pad[b*8 +: 8] = PAD_DOMAIN;
    end
  end

  // A full final beat pushes the domain byte into byte 0 of the following word.
  always_comb begin
    padded = RATE_MAX'(beat_pad) << (int'(word_pos) * DATA_WIDTH);
    if (int'(nbytes) == BPW)
      padded = padded | (RATE_MAX'(PAD_DOMAIN) << ((int'(word_pos) + 1) * DATA_WIDTH));
    end_mask = '0;
    end_mask[(int'(rate) - 1) * 8 +: 8] = PAD_END;
  end

endmodule

// File: rtl/axis_sha3_block_packer.sv
// AXI-Stream to SHA3 rate-block packer with domain padding, TKEEP-aware tails,
// backpressure and extra pad-block generation when the message fills a block exactly.
module axis_sha3_block_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int RATE_MAX   = 1152
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_WIDTH-1:0]   TDATA,
  input  logic                    TVALID,
  output logic                    TREADY,
  input  logic                    TLAST,
  input  logic [DATA_WIDTH/8-1:0] TKEEP,
  input  logic [1:0]              TUSER,
  output logic [RATE_MAX-1:0]     blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_last,
  output logic [1:0]              blk_mode,
  output logic                    busy
);
  import sha3_axis_pkg::*;

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int NB_W  = $clog2(BPW + 1);
  localparam int POS_W = $clog2(RATE_MAX / DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_PAD  = 2'd3;

  logic [1:0]          state_p0;
  logic [POS_W-1:0]    cnt_p0;
  logic [RATE_MAX-1:0] blk_p0;
  logic                last_p0;
  logic                pend_p0;
  logic                busy_p0;
  logic                armed_p0;
  sha3_mode_t          mode_p0;

  sha3_mode_t          cur_mode;
  logic [7:0]          rate;
  logic [7:0]          rate_words;
  logic [NB_W-1:0]     nbytes;
  logic [NB_W-1:0]     pi_nbytes;
  logic [POS_W-1:0]    pi_pos;
  logic                accept;
  logic                at_end;
  logic                full_beat;
  logic [RATE_MAX-1:0] padded;
  logic [RATE_MAX-1:0] end_mask;

  // The first beat of a message is sized by TUSER before it is latched.
  assign cur_mode   = (state_p0 == S_IDLE) ? sha3_mode_t'(TUSER) : mode_p0;
  assign rate       = rate_bytes(cur_mode);
  assign rate_words = rate / 8'(BPW);
  assign at_end     = (8'(cnt_p0) == rate_words - 8'd1);
  assign nbytes     = NB_W'($countones(TKEEP));
  assign full_beat  = (int'(nbytes) == BPW);
  assign TREADY     = armed_p0 && ((state_p0 == S_IDLE) || (state_p0 == S_FILL));
  assign accept     = TVALID && TREADY;
  assign pi_nbytes  = (state_p0 == S_PAD) ? '0 : nbytes;
  assign pi_pos     = (state_p0 == S_PAD) ? '0 : cnt_p0;

  sha3_pad_inserter #(
    .DATA_WIDTH (DATA_WIDTH),
    .RATE_MAX   (RATE_MAX)
  ) u_pad (
    .beat     (TDATA),
    .nbytes   (pi_nbytes),
    .word_pos (pi_pos),
    .mode     (cur_mode),
    .padded   (padded),
    .end_mask (end_mask)
  );

  // Stage p0: FSM, word counter and block buffer
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_p0 <= S_IDLE;
      cnt_p0   <= '0;
      blk_p0   <= '0;
      last_p0  <= 1'b0;
      pend_p0  <= 1'b0;
      busy_p0  <= 1'b0;
      armed_p0 <= 1'b0;
      mode_p0  <= SHA3_224;
    end else begin
      armed_p0 <= 1'b1;
      case (state_p0)
        S_IDLE, S_FILL: begin
          if (accept) begin
            if (state_p0 == S_IDLE) begin
              mode_p0 <= sha3_mode_t'(TUSER);
              busy_p0 <= 1'b1;
            end
            if (TLAST && !(full_beat && at_end)) begin
              blk_p0   <= blk_p0 | padded | end_mask;
              last_p0  <= 1'b1;
              state_p0 <= S_EMIT;
            end else begin
              blk_p0[int'(cnt_p0)*DATA_WIDTH +: DATA_WIDTH] <= TDATA;
              if (at_end) begin
                // An exactly-full final block still owes a pad-only block.
                pend_p0  <= TLAST;
                last_p0  <= 1'b0;
                state_p0 <= S_EMIT;
              end else begin
                cnt_p0   <= cnt_p0 + 1'b1;
                state_p0 <= S_FILL;
              end
            end
          end
        end
        S_EMIT: begin
          if (blk_ready) begin
            blk_p0  <= '0;
            cnt_p0  <= '0;
            last_p0 <= 1'b0;
            if (pend_p0) begin
              pend_p0  <= 1'b0;
              state_p0 <= S_PAD;
            end else if (last_p0) begin
              busy_p0  <= 1'b0;
              state_p0 <= S_IDLE;
            end else begin
              state_p0 <= S_FILL;
            end
          end
        end
        default: begin
          blk_p0   <= padded | end_mask;
          last_p0  <= 1'b1;
          state_p0 <= S_EMIT;
        end
      endcase
    end
  end

  assign blk_data  = blk_p0;
  assign blk_valid = (state_p0 == S_EMIT);
  assign blk_last  = last_p0;
  assign blk_mode  = mode_p0;
  assign busy      = busy_p0;

endmodule

// File: tb/tb_axis_sha3_block_packer.sv
// Directed bench for axis_sha3_block_packer: hand-computed padded blocks per mode.
module tb_axis_sha3_block_packer;

  localparam int DW = 64;
  localparam int RM = 1152;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [DW-1:0] TDATA = '0;
  logic          TVALID = 1'b0;
  logic          TREADY;
  logic          TLAST = 1'b0;
  logic [7:0]    TKEEP = '0;
  logic [1:0]    TUSER = '0;
  logic [RM-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          blk_last;
  logic [1:0]    blk_mode;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [RM-1:0] g1, g2, exp_blk;
  logic          l1, l2;
  logic [1:0]    m1, m2;

  axis_sha3_block_packer #(.DATA_WIDTH(DW), .RATE_MAX(RM)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .TDATA     (TDATA),
    .TVALID    (TVALID),
    .TREADY    (TREADY),
    .TLAST     (TLAST),
    .TKEEP     (TKEEP),
    .TUSER     (TUSER),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .blk_mode  (blk_mode),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [RM-1:0] got, input logic [RM-1:0] exp);
    for (int w = 0; w < RM/64; w++)
      chk($sformatf("%s w%0d", tag, w), got[w*64 +: 64], exp[w*64 +: 64]);
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {8{b}};
  endfunction

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] k, input logic [1:0] u);
    int guard;
    guard = 0;
    TDATA = d; TLAST = l; TKEEP = k; TUSER = u; TVALID = 1'b1;
    while (!TREADY && guard < 100) begin
      @(negedge ACLK);
      guard++;
    end
    if (guard >= 100) chk("tready timeout", 64'(TREADY), 64'd1);
    @(negedge ACLK);
    TVALID = 1'b0; TLAST = 1'b0; TKEEP = '0;
  endtask

  task automatic get_blk(input int hold, output logic [RM-1:0] d, output logic l, output logic [1:0] m);
    int guard;
    guard = 0;
    while (!blk_valid && guard < 200) begin
      @(negedge ACLK);
      guard++;
    end
    chk("blk_valid seen", 64'(blk_valid), 64'd1);
    d = blk_data; l = blk_last; m = blk_mode;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk("hold tready", 64'(TREADY), 64'd0);
      chk("hold valid", 64'(blk_valid), 64'd1);
      chk("hold data stable", 64'(blk_data != d), 64'd0);
    end
    blk_ready = 1'b1;
    @(negedge ACLK);
    blk_ready = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk({tag, " tready"}, 64'(TREADY), 64'd0);
    chk({tag, " valid"}, 64'(blk_valid), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " last"}, 64'(blk_last), 64'd0);
    chk({tag, " mode"}, 64'(blk_mode), 64'd0);
    chk({tag, " data zero"}, 64'(blk_data != '0), 64'd0);
    ARESET = 1'b0;
  endtask

  initial begin
    @(negedge ACLK);
    @(negedge ACLK);
    reset_check("reset");

    // Empty message, mode 256: pad-only block
    send_beat(64'hDEAD_BEEF_0123_4567, 1'b1, 8'h00, 2'd1);
    chk("t1 valid latency", 64'(blk_valid), 64'd1);
    chk("t1 busy", 64'(busy), 64'd1);
    chk("t1 tready in emit", 64'(TREADY), 64'd0);
    get_blk(0, g1, l1, m1);
    exp_blk = '0; exp_blk[7:0] = 8'h06; exp_blk[135*8 +: 8] = 8'h80;
    chk_blk("t1 blk", g1, exp_blk);
    chk("t1 last", 64'(l1), 64'd1);
    chk("t1 mode", 64'(m1), 64'd1);
    chk("t1 busy done", 64'(busy), 64'd0);
    chk("t1 valid done", 64'(blk_valid), 64'd0);

    // "abc", garbage above TKEEP must be dropped
    send_beat(64'hAAAA_AAAA_AA63_6261, 1'b1, 8'h07, 2'd1);
    get_blk(0, g1, l1, m1);
    exp_blk = '0; exp_blk[63:0] = 64'h0000_0000_0663_6261; exp_blk[135*8 +: 8] = 8'h80;
    chk_blk("t2 blk", g1, exp_blk);
    chk("t2 last", 64'(l1), 64'd1);

    // 136 bytes exactly fill one mode-1 block, then a pad-only block follows
    for (int i = 0; i < 17; i++) send_beat(pat(i), i == 16, 8'hFF, 2'd1);
    get_blk(0, g1, l1, m1);
    chk("t3 busy mid", 64'(busy), 64'd1);
    get_blk(0, g2, l2, m2);
    exp_blk = '0;
    for (int i = 0; i < 17; i++) exp_blk[i*64 +: 64] = pat(i);
    chk_blk("t3 blk1", g1, exp_blk);
    chk("t3 last1", 64'(l1), 64'd0);
    exp_blk = '0; exp_blk[7:0] = 8'h06; exp_blk[135*8 +: 8] = 8'h80;
    chk_blk("t3 blk2", g2, exp_blk);
    chk("t3 last2", 64'(l2), 64'd1);
    chk("t3 mode2", 64'(m2), 64'd1);
    chk("t3 busy done", 64'(busy), 64'd0);

    // Mode 512, 71 bytes: pad byte lands on rate-1 and becomes 0x86
    for (int i = 0; i < 8; i++) send_beat(pat(i), 1'b0, 8'hFF, 2'd3);
    send_beat(64'hFFEE_DDCC_BBAA_9988, 1'b1, 8'h7F, 2'd0);
    get_blk(0, g1, l1, m1);
    exp_blk = '0;
    for (int i = 0; i < 8; i++) exp_blk[i*64 +: 64] = pat(i);
    exp_blk[8*64 +: 64] = 64'h86EE_DDCC_BBAA_9988;
    chk_blk("t4 blk", g1, exp_blk);
    chk("t4 last", 64'(l1), 64'd1);
    chk("t4 mode", 64'(m1), 64'd3);

    // Two-block message with 5 cycles of downstream backpressure
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(pat(i), i == 19, 8'hFF, 2'd1);
      end
      begin
        get_blk(5, g1, l1, m1);
        get_blk(0, g2, l2, m2);
      end
    join
    exp_blk = '0;
    for (int i = 0; i < 17; i++) exp_blk[i*64 +: 64] = pat(i);
    chk_blk("t5 blk1", g1, exp_blk);
    chk("t5 last1", 64'(l1), 64'd0);
    exp_blk = '0;
    for (int i = 0; i < 3; i++) exp_blk[i*64 +: 64] = pat(17 + i);
    exp_blk[3*64 +: 8] = 8'h06;
    exp_blk[135*8 +: 8] = 8'h80;
    chk_blk("t5 blk2", g2, exp_blk);
    chk("t5 last2", 64'(l2), 64'd1);

    // Reset mid-FILL, then during EMIT, then a clean mode-224 "abc"
    for (int i = 0; i < 4; i++) send_beat(pat(i), 1'b0, 8'hFF, 2'd1);
    chk("t6 busy fill", 64'(busy), 64'd1);
    reset_check("t6 rst fill");
    for (int i = 0; i < 17; i++) send_beat(pat(i), 1'b0, 8'hFF, 2'd1);
    chk("t6 emit before rst", 64'(blk_valid), 64'd1);
    reset_check("t6 rst emit");
    send_beat(64'h0000_0000_0063_6261, 1'b1, 8'h07, 2'd0);
    get_blk(0, g1, l1, m1);
    exp_blk = '0; exp_blk[63:0] = 64'h0000_0000_0663_6261; exp_blk[143*8 +: 8] = 8'h80;
    chk_blk("t6 blk", g1, exp_blk);
    chk("t6 last", 64'(l1), 64'd1);
    chk("t6 mode", 64'(m1), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_sha3_block_packer.md
Name: axis_sha3_block_packer

Overview:
Parametrised AXI-Stream slave that gathers message beats into one SHA3 rate-sized block and applies SHA3 domain padding (0x06…0x80). It hands each complete block to the Keccak absorb stage over a valid/ready handshake. It replaces the single-word receiver and adds a TUSER-selected mode, TKEEP-aware final beats, real backpressure and extra-pad-block generation. It sits between the AXIS input and the sponge core.

Parameters:
DATA_WIDTH, 64, TDATA width in bits; legal values are 32 or 64.
RATE_MAX, 1152, block buffer width in bits (the SHA3-224 rate).

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  synchronous active-high reset.
TDATA  in  DATA_WIDTH  message beat; byte 0 is the lowest-address byte.
TVALID  in  1  beat valid.
TREADY  out  1  beat accepted when TVALID && TREADY.
TLAST  in  1  final beat of the message.
TKEEP  in  DATA_WIDTH/8  byte enables; only honoured on the TLAST beat.
TUSER  in  2  mode: 0=224, 1=256, 2=384, 3=512.
blk_data  out  RATE_MAX  padded block; beat k sits at [k*DATA_WIDTH +: DATA_WIDTH]; bits above the rate are 0.
blk_valid  out  1  block available.
blk_ready  in  1  downstream accepts the block.
blk_last  out  1  block is the final (padded) block of the message.
blk_mode  out  2  mode latched for the message.
busy  out  1  high from the first accepted beat until the last block is accepted.

Behaviour:
- Reset (ARESET=1 on a clock edge): go to IDLE. TREADY=0, blk_valid=0, blk_last=0, blk_mode=0, busy=0, blk_data=0. Any partial message is discarded, including during EMIT.
- Rates in bytes: 144, 136, 104, 72. Words per block: RATE_WORDS = rate*8/DATA_WIDTH, looked up from the latched mode.
- States:
  - IDLE: TREADY=1. On the first accepted beat, latch TUSER into blk_mode, set busy, then handle the beat as in FILL.
  - FILL: TREADY=1. Each accepted beat is written at the word counter position and the counter increments.
  - EMIT: TREADY=0 and blk_valid=1. blk_data, blk_last and blk_mode are held stable until blk_ready. On handshake, go to PAD if pad_pending, otherwise to FILL (not last) or IDLE (last, busy drops).
  - PAD: builds a block with byte0=0x06, byte[rate-1]=0x80 and all other bytes 0. Enters EMIT with blk_last=1 one cycle later.
- Transitions out of FILL on an accepted beat:
  - Non-last beat, counter == RATE_WORDS-1: EMIT next cycle, blk_last=0.
  - TLAST beat with n = popcount(TKEEP) valid bytes (TKEEP must be contiguous from the LSB; n=0 is legal and means an empty tail):
    - If the pad byte offset p = counter*DATA_WIDTH/8 + n is < rate: bytes ≥ n in this beat are zeroed, byte p ^= 0x06, byte[rate-1] |= 0x80 (0x86 when p == rate-1), words above the beat are zeroed. Then EMIT with blk_last=1.
    - If p == rate (the beat fills the block exactly): EMIT the data block with blk_last=0 and pad_pending=1.
- Non-last beats are treated as full width; TKEEP is ignored on them.
- TUSER is ignored after the first beat of a message.
- Latency: the block-completing beat is accepted at edge t, and blk_valid=1 from edge t+1.
- Word counter: clears on each EMIT handshake, never exceeds RATE_WORDS-1, and has no wrap.
- Throughput: 1 beat/cycle while filling. TREADY drops only in EMIT/PAD, so each block costs at least 1 bubble cycle.
- blk_valid never depends combinationally on blk_ready. blk_data for unused words is always 0.

Decomposition:
- Package sha3_axis_pkg holds:
  - mode enum sha3_mode_t (SHA3_224..SHA3_512);
  - function rate_bytes(mode);
  - constants PAD_DOMAIN=8'h06, PAD_END=8'h80, RATE_MAX.
- One sub-module, sha3_pad_inserter: combinational; takes the beat, n, word position and mode, and returns the padded beat plus the end-byte mask. The FSM, buffer and counters stay in the top.

Test Plan:
- Mode 1, single beat TLAST=1, TKEEP=0 → one block: byte0=0x06, byte135=0x80, all else 0, blk_last=1, blk_mode=1.
- Mode 1, "abc" as TDATA=0x636261, TKEEP=0x07, TLAST → block word0=0x0000_0000_0663_6261, byte135=0x80, blk_last=1.
- Mode 1, 17 full 64-bit beats, TLAST on beat 17 with TKEEP=0xFF → block 1 carries the data with blk_last=0, then block 2 is pad-only (0x06 / byte135 0x80) with blk_last=1.
- Mode 3, 71-byte message (8 full beats + TKEEP=0x7F) → byte71=0x86, blk_last=1, and words 9..17 are 0.
- Mode 1, two-block message with blk_ready held low for 5 cycles in EMIT → TREADY=0 and blk_data stable throughout, no beats lost, and the second block's contents are correct.
- ARESET asserted mid-FILL after 4 beats and again during EMIT → next cycle blk_valid=0, busy=0, TREADY=0. A following "abc" message yields a clean single block with no stale data.
